pwm_decoder: RTL

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_decoder_synchronizer.sv | 25 ++
 rtl/pwm_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: decoder FSM encoding and the window length common to DAC and decoder.
package pwm_pkg;
  localparam int PWM_CYCLES_PER_WINDOW = 1024;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;
endpackage

// File: rtl/pwm_decoder_synchronizer.sv
// Two-flop synchroniser for asynchronous level inputs.
// Latency 2 clk; free-running, no backpressure.
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;
endmodule

// File: rtl/pwm_decoder.sv
// PWM duty decoder: recovers the DAC code from the high time of each window, flags bad periods.
// Latency: code_valid 1 clk after the synchronised rising edge; free-running, no backpressure.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int CYCLES_PER_WINDOW = PWM_CYCLES_PER_WINDOW,
  parameter int CODE_WIDTH        = 10,
  parameter int TIMEOUT           = 2 * CYCLES_PER_WINDOW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwm_in,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  code_valid,
  output logic                  period_err,
  output logic                  locked
);
  localparam int CW    = $clog2(TIMEOUT) + 1;
  localparam int CMP_W = (CW > CODE_WIDTH) ? CW : CODE_WIDTH;
  localparam logic [CW-1:0]         CPW_C    = CW'(CYCLES_PER_WINDOW);
  localparam logic [CW-1:0]         TMO_C    = CW'(TIMEOUT);
  localparam logic [CW-1:0]         ONE_C    = CW'(1);
  localparam logic [CODE_WIDTH-1:0] CODE_MAX = '1;

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  logic                  w_s;
  logic                  r_s_d;
  logic                  w_rise;
  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_icnt, r_pcnt, r_hcnt;
  logic [CW-1:0]         w_icnt_nxt, w_pcnt_nxt, w_hcnt_nxt, w_icnt_inc;
  logic [CODE_WIDTH-1:0] r_code, w_code_nxt, w_code_clip, w_code_lvl;
  logic                  r_code_valid, r_period_err, r_locked;
  logic                  w_vld_nxt, w_perr_nxt, w_lock_nxt;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  synchronizer #(.WIDTH(1)) u_sync (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_async (pwm_in),
    .o_sync  (w_s)
  );

  assign w_rise      = w_s & ~r_s_d;
  assign w_icnt_inc  = r_icnt + ONE_C;
  assign w_code_lvl  = w_s ? CODE_MAX : '0;
  assign w_code_clip = (CMP_W'(r_hcnt) > CMP_W'(CODE_MAX)) ? CODE_MAX : CODE_WIDTH'(r_hcnt);

  always_comb begin
    w_state_nxt = r_state;
    w_icnt_nxt  = r_icnt;
    w_pcnt_nxt  = r_pcnt;
    w_hcnt_nxt  = r_hcnt;
    w_code_nxt  = r_code;
    w_vld_nxt   = 1'b0;
    w_perr_nxt  = 1'b0;
    w_lock_nxt  = r_locked;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_pcnt_nxt  = ONE_C;
          w_hcnt_nxt  = ONE_C;
          w_icnt_nxt  = '0;
        end else if (w_icnt_inc == CPW_C) begin
          w_vld_nxt  = 1'b1;
          w_code_nxt = w_code_lvl;
          w_lock_nxt = 1'b0;
          w_icnt_nxt = '0;
        end else begin
          w_icnt_nxt = w_icnt_inc;
        end
      end
      MEASURE: begin
        // A rise on the timeout cycle still closes the window normally.
        if (w_rise) begin
          w_vld_nxt  = 1'b1;
          w_code_nxt = w_code_clip;
          w_perr_nxt = (r_pcnt != CPW_C);
          w_lock_nxt = (r_pcnt == CPW_C);
          w_pcnt_nxt = ONE_C;
          w_hcnt_nxt = ONE_C;
        end else if (r_pcnt >= TMO_C) begin
          w_vld_nxt   = 1'b1;
          w_code_nxt  = w_code_lvl;
          w_perr_nxt  = 1'b1;
          w_lock_nxt  = 1'b0;
          w_state_nxt = IDLE;
          w_icnt_nxt  = '0;
        end else begin
          w_pcnt_nxt = (r_pcnt == '1) ? r_pcnt : r_pcnt + ONE_C;
          w_hcnt_nxt = r_hcnt + CW'(w_s);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= IDLE;
      r_s_d        <= 1'b0;
      r_icnt       <= '0;
      r_pcnt       <= '0;
      r_hcnt       <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_period_err <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_s_d        <= w_s;
      r_icnt       <= w_icnt_nxt;
      r_pcnt       <= w_pcnt_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_code       <= w_code_nxt;
      r_code_valid <= w_vld_nxt;
      r_period_err <= w_perr_nxt;
      r_locked     <= w_lock_nxt;
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign period_err = r_period_err;
  assign locked     = r_locked;
endmodule
